// File: rtl/tdm_mac_pkg.sv
// tdm_mac_pkg: shared definitions for the TDM multiply-accumulate engine.
//   ch_w()      - channel index width for a given channel count (min 1 bit)
//   ST_*        - edge index, counted from the capture edge, at which each
//                 pipeline register holds a given sample
//   mac_ctl_t   - framing/control bundle travelling alongside the data
package tdm_mac_pkg;

  // Widest channel index the struct must carry (NUM_CH <= 64).
  localparam int unsigned CH_W_MAX = 6;

  // Pipeline register positions, 1-based from the capture edge.
  localparam int unsigned ST_A1  = 1;  // operand register 1 (DSP A1/B1)
  localparam int unsigned ST_A2  = 2;  // operand register 2 (DSP A2/B2)
  localparam int unsigned ST_M   = 3;  // multiplier register (DSP M)
  localparam int unsigned ST_P   = 4;  // extended product register
  localparam int unsigned ST_ACC = 5;  // accumulate / burst-sum register
  localparam int unsigned ST_OUT = 6;  // output register

  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
    logic                first;
    logic                last;
  } mac_ctl_t;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_mac_mult.sv
// tdm_mac_mult: three-stage registered multiplier shaped for one DSP48E1
// (AREG=2, BREG=2, MREG=1). Data registers carry no reset so that they
// fold into the DSP slice.
//   clk  in               rising-edge clock
//   a    in  WIDTH_A      operand A
//   b    in  WIDTH_B      operand B
//   p    out WIDTH_A+WIDTH_B  product of the operands presented 3 edges earlier
(* use_dsp = "yes" *)
module tdm_mac_mult #(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic                       clk,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic [WIDTH_A+WIDTH_B-1:0] p
);

  localparam int unsigned PW = WIDTH_A + WIDTH_B;

  logic [WIDTH_A-1:0] a1_d, a1_q, a2_d, a2_q;
  logic [WIDTH_B-1:0] b1_d, b1_q, b2_d, b2_q;
  logic signed [PW-1:0] op_a, op_b;
  logic [PW-1:0] m_d, m_q;

  always_comb begin
    a1_d = a;
    b1_d = b;
    a2_d = a1_q;
    b2_d = b1_q;
    // Extend both operands to full product width first; the low PW bits of
    // the product are then exact in either mode.
    if (SIGNED) begin
      op_a = PW'($signed(a2_q));
      op_b = PW'($signed(b2_q));
    end else begin
      op_a = PW'(a2_q);
      op_b = PW'(b2_q);
    end
    m_d = op_a * op_b;
  end

  always_ff @(posedge clk) begin
    a1_q <= a1_d;
    b1_q <= b1_d;
    a2_q <= a2_d;
    b2_q <= b2_d;
    m_q  <= m_d;
  end

  assign p = m_q;

endmodule

// File: rtl/tdm_mac.sv
// tdm_mac: TDM, fully pipelined multiply-accumulate engine for burst data.
// Products of din_a*din_b are summed per channel across a burst framed by
// in_first/in_last; one result per burst appears 5 edges after the edge that
// captured the in_last sample. No backpressure, one sample per cycle.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid             sample valid
//   in_ch     CH_W       channel index (>= NUM_CH: sample dropped)
//   in_first, in_last    burst framing
//   din_a/din_b          operands
//   out_valid            single-cycle result pulse
//   out_ch    CH_W       channel of the result (held between pulses)
//   out_acc   ACC_WIDTH  burst sum, wraps modulo 2^ACC_WIDTH (held)
//   out_ovf              accumulator overflowed at least once in the burst
module tdm_mac
  import tdm_mac_pkg::*;
#(
  parameter int unsigned WIDTH_A   = 8,
  parameter int unsigned WIDTH_B   = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ACC_WIDTH = WIDTH_A + WIDTH_B + 8,
  parameter bit          SIGNED    = 1'b1,
  localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH_W-1:0]      in_ch,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [WIDTH_A-1:0]   din_a,
  input  logic [WIDTH_B-1:0]   din_b,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf
);

  localparam int unsigned PW  = WIDTH_A + WIDTH_B;
  localparam int unsigned MSB = ACC_WIDTH - 1;

  // Control pipeline alongside the multiplier (A1, A2, M)
  mac_ctl_t ctl_d [ST_M];
  mac_ctl_t ctl_q [ST_M];

  logic [PW-1:0] prod;

  // Extended product stage
  mac_ctl_t             p_ctl_d, p_ctl_q;
  logic [ACC_WIDTH-1:0] p_d, p_q;

  // Accumulator bank
  logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
  logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
  logic [NUM_CH-1:0]    ovf_d, ovf_q;

  // Burst-sum stage
  logic                 sum_valid_d, sum_valid_q;
  logic [CH_W-1:0]      sum_ch_d, sum_ch_q;
  logic [ACC_WIDTH-1:0] sum_acc_d, sum_acc_q;
  logic                 sum_ovf_d, sum_ovf_q;

  // Output register
  logic                 out_valid_d, out_valid_q;
  logic [CH_W-1:0]      out_ch_d, out_ch_q;
  logic [ACC_WIDTH-1:0] out_acc_d, out_acc_q;
  logic                 out_ovf_d, out_ovf_q;

  // Accumulate-stage temporaries
  logic [CH_W-1:0]      c;
  logic [ACC_WIDTH:0]   wide;
  logic [ACC_WIDTH-1:0] nsum;
  logic                 step_ovf, novf;

  tdm_mac_mult #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B),
    .SIGNED  (SIGNED)
  ) u_mult (
    .clk (clk),
    .a   (din_a),
    .b   (din_b),
    .p   (prod)
  );

  always_comb begin
    ctl_d[0].valid = in_valid;
    ctl_d[0].ch    = CH_W_MAX'(in_ch);
    ctl_d[0].first = in_first;
    ctl_d[0].last  = in_last;
    for (int unsigned i = 1; i < ST_M; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
  end

  always_comb begin
    p_ctl_d = ctl_q[ST_M-1];
    // Out-of-range channels are dropped here, before they can touch the bank.
    p_ctl_d.valid = ctl_q[ST_M-1].valid &&
                    ({1'b0, ctl_q[ST_M-1].ch} < (CH_W_MAX+1)'(NUM_CH));
    if (SIGNED) begin
      p_d = ACC_WIDTH'($signed(prod));
    end else begin
      p_d = ACC_WIDTH'(prod);
    end
  end

  // Single-cycle read-modify-write of the bank, so back-to-back samples on
  // one channel always see the previous sample's update.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    c     = p_ctl_q.ch[CH_W-1:0];
    wide  = {1'b0, acc_q[c]} + {1'b0, p_q};
    if (SIGNED) begin
      step_ovf = (acc_q[c][MSB] == p_q[MSB]) && (wide[MSB] != acc_q[c][MSB]);
    end else begin
      step_ovf = wide[ACC_WIDTH];
    end
    if (p_ctl_q.first) begin
      nsum = p_q;
      novf = 1'b0;
    end else begin
      nsum = wide[ACC_WIDTH-1:0];
      novf = ovf_q[c] | step_ovf;
    end
    sum_valid_d = p_ctl_q.valid && p_ctl_q.last;
    sum_ch_d    = c;
    sum_acc_d   = nsum;
    sum_ovf_d   = novf;
    if (p_ctl_q.valid) begin
      if (p_ctl_q.last) begin
        acc_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else begin
        acc_d[c] = nsum;
        ovf_d[c] = novf;
      end
    end
  end

  always_comb begin
    out_valid_d = sum_valid_q;
    out_ch_d    = out_ch_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    if (sum_valid_q) begin
      out_ch_d  = sum_ch_q;
      out_acc_d = sum_acc_q;
      out_ovf_d = sum_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ST_M; i++) begin
        ctl_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      p_ctl_q     <= '0;
      p_q         <= '0;
      ovf_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_ch_q    <= '0;
      sum_acc_q   <= '0;
      sum_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      ctl_q       <= ctl_d;
      acc_q       <= acc_d;
      p_ctl_q     <= p_ctl_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
      sum_ch_q    <= sum_ch_d;
      sum_acc_q   <= sum_acc_d;
      sum_ovf_q   <= sum_ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_tdm_mac.sv
// tb_tdm_mac: self-checking bench for tdm_mac. A signed 4-channel instance
// and an unsigned 5-channel instance share clock and reset. A per-channel
// arithmetic model predicts every burst result and its arrival edge.
module tb_tdm_mac;

  typedef struct {
    int     inst;
    int     cyc;
    int     ch;
    longint acc;
    bit     ovf;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0;
  logic [1:0]  s_ch = '0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic        s_ov, s_oovf;
  logic [1:0]  s_och;
  logic [23:0] s_oacc;

  logic        u_valid = 1'b0, u_first = 1'b0, u_last = 1'b0;
  logic [2:0]  u_ch = '0;
  logic [7:0]  u_a = '0, u_b = '0;
  logic        u_ov, u_oovf;
  logic [2:0]  u_och;
  logic [23:0] u_oacc;

  tdm_mac u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ch(s_ch),
    .in_first(s_first), .in_last(s_last), .din_a(s_a), .din_b(s_b),
    .out_valid(s_ov), .out_ch(s_och), .out_acc(s_oacc), .out_ovf(s_oovf)
  );

  tdm_mac #(.NUM_CH(5), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_valid), .in_ch(u_ch),
    .in_first(u_first), .in_last(u_last), .din_a(u_a), .din_b(u_b),
    .out_valid(u_ov), .out_ch(u_och), .out_acc(u_oacc), .out_ovf(u_oovf)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  longint macc [2][8];
  bit     movf [2][8];

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (s_ov) obs_q.push_back('{0, cyc, int'(s_och), longint'($signed(s_oacc)), s_oovf});
    if (u_ov) obs_q.push_back('{1, cyc, int'(u_och), longint'(u_oacc), u_oovf});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // Reduce an exact integer to the 24-bit accumulator's value range.
  function automatic longint wrap24(input bit sgn, input longint x);
    longint r;
    r = x & 64'sh0000_0000_00FF_FFFF;
    if (sgn && r >= 64'sd8388608) r = r - 64'sd16777216;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) begin
        macc[i][j] = 0;
        movf[i][j] = 1'b0;
      end
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    u_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply one sample to instance inst (0 signed, 1 unsigned) and update model.
  task automatic drive(input int inst, input bit v, input int ch, input bit f,
                       input bit l, input int a, input int b);
    bit     sgn;
    int     pa, pb;
    longint p, ex, val;
    bit     o;
    sgn = (inst == 0);
    if (sgn) begin
      s_valid = v; s_ch = ch[1:0]; s_first = f; s_last = l;
      s_a = a[7:0]; s_b = b[7:0]; u_valid = 1'b0;
    end else begin
      u_valid = v; u_ch = ch[2:0]; u_first = f; u_last = l;
      u_a = a[7:0]; u_b = b[7:0]; s_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (v && ch < (sgn ? 4 : 5)) begin
      pa = sgn ? int'($signed(a[7:0])) : int'(a[7:0]);
      pb = sgn ? int'($signed(b[7:0])) : int'(b[7:0]);
      p  = longint'(pa) * longint'(pb);
      if (f) begin
        val = p;
        o   = 1'b0;
      end else begin
        ex  = macc[inst][ch] + p;
        val = wrap24(sgn, ex);
        o   = movf[inst][ch] | (ex != val);
      end
      if (l) begin
        exp_q.push_back('{inst, cyc + 5, ch, val, o});
        macc[inst][ch] = 0;
        movf[inst][ch] = 1'b0;
      end else begin
        macc[inst][ch] = val;
        movf[inst][ch] = o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_vec++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid: got %b want 0", s_ov); end
    n_vec++; if (s_och !== 2'd0) begin n_bad++; $display("FAIL reset_s_ch: got %0d want 0", s_och); end
    n_vec++; if (s_oacc !== 24'd0) begin n_bad++; $display("FAIL reset_s_acc: got %0d want 0", s_oacc); end
    n_vec++; if (s_oovf !== 1'b0) begin n_bad++; $display("FAIL reset_s_ovf: got %b want 0", s_oovf); end
    n_vec++; if (u_ov !== 1'b0) begin n_bad++; $display("FAIL reset_u_valid: got %b want 0", u_ov); end
    n_vec++; if (u_oacc !== 24'd0) begin n_bad++; $display("FAIL reset_u_acc: got %0d want 0", u_oacc); end
    rst_n = 1'b1;
    model_clear();
    idle(2);
  endtask

  task automatic test_basic();
    ev_t e, o;
    drive(0, 1, 0, 1, 0, 3, 4);
    drive(0, 1, 0, 0, 0, -2, 5);
    drive(0, 1, 0, 0, 1, 7, -1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL basic_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL basic_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL basic_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_interleave();
    ev_t e, o;
    drive(0, 1, 1, 1, 0, 2, 3);
    drive(0, 1, 2, 1, 1, 4, 4);
    drive(0, 1, 1, 0, 1, 5, 5);
    for (int i = 0; i < 250; i++)
      drive(0, $urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 255));
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL interleave_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL interleave_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL interleave_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_overflow();
    ev_t e, o;
    for (int i = 1; i <= 513; i++)
      drive(0, 1, 3, i == 1, i == 513, -128, -128);
    drive(0, 1, 3, 1, 1, 5, 5);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL overflow_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL overflow_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL overflow_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_unsigned_drop();
    ev_t e, o;
    drive(1, 1, 0, 1, 1, 255, 255);
    drive(1, 1, 0, 1, 0, 2, 3);
    drive(1, 1, 5, 1, 1, 9, 9);
    drive(1, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 200; i++)
      drive(1, $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 255), $urandom_range(0, 255));
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL unsigned_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL unsigned_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL unsigned_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    ev_t e, o;
    drive(0, 1, 0, 1, 0, 10, 10);
    drive(0, 1, 1, 1, 1, 3, 3);
    s_valid = 1'b0;
    u_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    drive(0, 1, 0, 0, 1, 1, 1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL midreset_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL midreset_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midreset_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    drive(0, 1, 0, 1, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 1, 1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_missing: got none want ch%0d acc %0d @%0d", e.ch, e.acc, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.inst != e.inst || o.cyc != e.cyc || o.ch != e.ch || o.acc != e.acc || o.ovf != e.ovf) begin
          n_bad++; $display("FAIL b2b_result: got i%0d @%0d ch%0d acc %0d ovf %0d want i%0d @%0d ch%0d acc %0d ovf %0d",
                            o.inst, o.cyc, o.ch, o.acc, o.ovf, e.inst, e.cyc, e.ch, e.acc, e.ovf);
        end
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra outputs want 0", obs_q.size()); obs_q.delete(); end
    n_vec++; if (s_oacc !== 24'd3) begin n_bad++; $display("FAIL hold_acc: got %0d want 3", s_oacc); end
    n_vec++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL hold_valid: got %b want 0", s_ov); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_overflow();
    test_unsigned_drop();
    test_reset_midflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
